// File: rtl/board_mem.sv
// Board cell store: WIDTH x HEIGHT 2-bit cells, request/response access, sweep clear, occupancy count.
// Define BOARD_MEM_WAIT_EN to insert one WAIT cycle between acceptance and response.
module board_mem #(
  parameter int WIDTH  = 6,
  parameter int HEIGHT = 6
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       mem_in_valid,
  input  logic [2:0] mem_addr_x,
  input  logic [2:0] mem_addr_y,
  input  logic       mem_wr_en,
  input  logic [1:0] mem_wr_data,
  output logic [1:0] mem_rd_data,
  output logic       mem_ready,
  output logic       mem_err,
  input  logic       clr_start,
  output logic       clr_busy,
  output logic [5:0] occ_cnt
);

  localparam int CELLS = WIDTH * HEIGHT;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_CLEAR, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [CELLS-1:0][1:0]  cell_q, cell_d;
  logic [CELLS-1:0]       hit, clr_hit;
  logic [IDX_W-1:0]       clr_idx_q, clr_idx_d;
  logic [1:0]             rd_old, clr_old;
  logic [1:0]             rd_data_q, rd_data_d;
  logic                   err_q, err_d;
  logic [5:0]             occ_q, occ_d;
  logic                   accept, legal, clr_last;
`ifdef BOARD_MEM_WAIT_EN
  logic [1:0]             hold_q, hold_d;
`endif

  assign accept   = (state_q == S_IDLE) && mem_in_valid && !clr_start;
  assign legal    = |hit;
  assign clr_last = (clr_idx_q == IDX_W'(CELLS - 1));

  // Each cell decodes its own (x,y); an out-of-range address simply hits nothing.
  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
      localparam logic [2:0] CX = 3'(gi % WIDTH);
      localparam logic [2:0] CY = 3'(gi / WIDTH);
      assign hit[gi]     = (mem_addr_x == CX) && (mem_addr_y == CY);
      assign clr_hit[gi] = (clr_idx_q == IDX_W'(gi));
      assign cell_d[gi]  = ((state_q == S_CLEAR) && clr_hit[gi]) ? 2'b00 :
                           (accept && hit[gi] && mem_wr_en)       ? mem_wr_data :
                                                                    cell_q[gi];
    end
  endgenerate

  always_comb begin
    rd_old  = 2'b00;
    clr_old = 2'b00;
    for (int i = 0; i < CELLS; i++) begin
      rd_old  = rd_old  | (hit[i]     ? cell_q[i] : 2'b00);
      clr_old = clr_old | (clr_hit[i] ? cell_q[i] : 2'b00);
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (accept && legal && mem_wr_en) begin
      if ((rd_old == 2'b00) && (mem_wr_data != 2'b00))
        occ_d = occ_q + 6'd1;
      else if ((rd_old != 2'b00) && (mem_wr_data == 2'b00))
        occ_d = occ_q - 6'd1;
    end else if ((state_q == S_CLEAR) && (clr_old != 2'b00)) begin
      occ_d = occ_q - 6'd1;
    end
  end

  // Read value is taken at acceptance; with WAIT it is parked until the response edge.
  always_comb begin
    err_d     = accept ? !legal : err_q;
    clr_idx_d = (state_q == S_CLEAR) ? clr_idx_q + IDX_W'(1) : '0;
`ifdef BOARD_MEM_WAIT_EN
    hold_d    = accept ? rd_old : hold_q;
    rd_data_d = (state_q == S_WAIT) ? hold_q : rd_data_q;
`else
    rd_data_d = accept ? rd_old : rd_data_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (clr_start)
          state_d = S_CLEAR;
        else if (mem_in_valid)
`ifdef BOARD_MEM_WAIT_EN
          state_d = S_WAIT;
`else
          state_d = S_RESP;
`endif
      end
`ifdef BOARD_MEM_WAIT_EN
      S_WAIT:  state_d = S_RESP;
`endif
      S_RESP:  state_d = S_IDLE;
      S_CLEAR: if (clr_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state_q == S_RESP);
    mem_err   = (state_q == S_RESP) && err_q;
    clr_busy  = (state_q == S_CLEAR);
  end

  assign mem_rd_data = rd_data_q;
  assign occ_cnt     = occ_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cell_q    <= '0;
      clr_idx_q <= '0;
      rd_data_q <= 2'b00;
      err_q     <= 1'b0;
      occ_q     <= 6'd0;
`ifdef BOARD_MEM_WAIT_EN
      hold_q    <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      cell_q    <= cell_d;
      clr_idx_q <= clr_idx_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      occ_q     <= occ_d;
`ifdef BOARD_MEM_WAIT_EN
      hold_q    <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_board_mem.sv
// Scoreboard bench for board_mem: a cell model predicts each response, a monitor checks it.
module tb_board_mem;
  localparam int W = 6;
  localparam int H = 6;
`ifdef BOARD_MEM_WAIT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 0;
  logic       rstn = 0;
  logic       mem_in_valid = 0;
  logic [2:0] mem_addr_x = 0;
  logic [2:0] mem_addr_y = 0;
  logic       mem_wr_en = 0;
  logic [1:0] mem_wr_data = 0;
  logic [1:0] mem_rd_data;
  logic       mem_ready;
  logic       mem_err;
  logic       clr_start = 0;
  logic       clr_busy;
  logic [5:0] occ_cnt;

  board_mem #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rstn(rstn), .mem_in_valid(mem_in_valid),
    .mem_addr_x(mem_addr_x), .mem_addr_y(mem_addr_y),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_ready(mem_ready), .mem_err(mem_err),
    .clr_start(clr_start), .clr_busy(clr_busy), .occ_cnt(occ_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] mdl [H][W];
  int         mdl_occ = 0;
  logic [8:0] exp_q [$];
  logic [1:0] last_rd = 0;
  bit         mon_en = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_zero();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        mdl[yy][xx] = 2'b00;
    mdl_occ = 0;
  endtask

  // Responses: one line each; checks data, error flag and occupancy against the queued prediction.
  always @(negedge clk) begin
    if (!rstn) begin
      last_rd = 2'b00;
    end else if (mon_en) begin
      if (mem_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_ready", 1, 0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          $display("resp rd=%0d err=%0d occ=%0d (exp rd=%0d err=%0d occ=%0d)",
                   mem_rd_data, mem_err, occ_cnt, e[8:7], e[6], e[5:0]);
          check("rd_data", mem_rd_data, e[8:7]);
          check("err", mem_err, e[6]);
          check("occ", occ_cnt, e[5:0]);
        end
        last_rd = mem_rd_data;
      end else begin
        check("err_idle", mem_err, 0);
        check("rd_hold", mem_rd_data, last_rd);
      end
    end
  end

  task automatic do_req(input int x, input int y, input bit we, input logic [1:0] wd,
                        input bit with_clr, input int exp_lat);
    logic [1:0] old;
    bit legal, got;
    int lat, busy_n;
    @(posedge clk); #1;
    if (with_clr) mdl_zero();
    legal = (x < W) && (y < H);
    old = legal ? mdl[y][x] : 2'b00;
    if (legal && we) begin
      if (old == 0 && wd != 0) mdl_occ++;
      else if (old != 0 && wd == 0) mdl_occ--;
      mdl[y][x] = wd;
    end
    exp_q.push_back({old, !legal, 6'(mdl_occ)});
    mem_addr_x   = 3'(x);
    mem_addr_y   = 3'(y);
    mem_wr_en    = we;
    mem_wr_data  = wd;
    mem_in_valid = 1;
    clr_start    = with_clr;
    lat = 0; got = 0; busy_n = 0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      clr_start = 0;
      lat++;
      if (clr_busy) busy_n++;
      if (mem_ready) got = 1;
    end
    mem_in_valid = 0;
    $display("req x=%0d y=%0d we=%0d wd=%0d clr=%0d lat=%0d busy=%0d", x, y, we, wd, with_clr, lat, busy_n);
    check("latency", lat, exp_lat);
    check("busy_cycles", busy_n, with_clr ? 36 : 0);
  endtask

  initial begin
    mdl_zero();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1;
    check("rst_rd", mem_rd_data, 0);
    check("rst_ready", mem_ready, 0);
    check("rst_err", mem_err, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_occ", occ_cnt, 0);
    mon_en = 1;

    do_req(1, 1, 0, 2'b00, 0, LAT);
    do_req(1, 1, 1, 2'b01, 0, LAT);
    do_req(2, 1, 1, 2'b01, 0, LAT);
    do_req(1, 2, 1, 2'b01, 0, LAT);
    do_req(2, 1, 0, 2'b00, 0, LAT);
    do_req(2, 1, 1, 2'b01, 0, LAT);

    // Out-of-range addresses, then neighbours that a bad index would alias onto
    do_req(6, 0, 1, 2'b11, 0, LAT);
    do_req(0, 6, 0, 2'b00, 0, LAT);
    do_req(7, 7, 1, 2'b10, 0, LAT);
    do_req(0, 1, 0, 2'b00, 0, LAT);
    do_req(0, 0, 0, 2'b00, 0, LAT);

    // clr_start during the response cycle must be dropped
    clr_start = 1;
    @(posedge clk); #1;
    clr_start = 0;
    check("clr_in_resp", clr_busy, 0);
    @(posedge clk); #1;
    check("clr_in_resp2", clr_busy, 0);

    do_req(1, 1, 0, 2'b00, 1, 37 + LAT);
    do_req(2, 1, 0, 2'b00, 0, LAT);

    for (int i = 0; i < 40; i++)
      do_req($urandom_range(0, 6), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 0, LAT);

    // Reset ten cycles into a sweep: cells past the sweep point must still be zeroed
    do_req(5, 5, 1, 2'b10, 0, LAT);
    do_req(1, 2, 1, 2'b11, 0, LAT);
    @(posedge clk); #1;
    clr_start = 1;
    @(posedge clk); #1;
    clr_start = 0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_mid", clr_busy, 1);
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    mdl_zero();
    check("mid_rst_busy", clr_busy, 0);
    check("mid_rst_ready", mem_ready, 0);
    check("mid_rst_occ", occ_cnt, 0);
    check("mid_rst_rd", mem_rd_data, 0);
    do_req(5, 5, 0, 2'b00, 0, LAT);
    do_req(1, 2, 0, 2'b00, 0, LAT);
    do_req(3, 3, 1, 2'b11, 0, LAT);
    do_req(3, 3, 1, 2'b00, 0, LAT);

    repeat (3) @(posedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
